adc_cmd_scheduler: RTL and testbench



---
 rtl/adc_cmd_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_adc_cmd_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cmd_scheduler.sv
// Arbitrates host and calibration requests onto the ADC configuration controller's
// one-cycle init / DES pulses, tracking completion, timeout and the resulting ADC state.
module adc_cmd_scheduler #(
  parameter int unsigned PWRUP_CYCLES   = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 8192,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_req,
  input  logic [1:0] host_cmd,
  output logic       host_ack,
  output logic       host_err,
  input  logic       cal_req,
  input  logic [1:0] cal_cmd,
  output logic       cal_ack,
  output logic       cal_err,
  output logic       adc_init,
  output logic       adc_des_enable,
  output logic       adc_des_disable,
  input  logic       adc_done,
  input  logic       clr_timeout,
  output logic       busy,
  output logic       adc_ready,
  output logic       des_active,
  output logic       timeout_flag
);

  localparam int unsigned MaxA   = (PWRUP_CYCLES > TIMEOUT_CYCLES) ? PWRUP_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned MaxCnt = (MaxA > GAP_CYCLES) ? MaxA : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] PwrupLast   = CntW'(PWRUP_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);

  localparam logic [1:0] CmdInit   = 2'b01;
  localparam logic [1:0] CmdDesEn  = 2'b10;
  localparam logic [1:0] CmdDesDis = 2'b11;

  typedef enum logic [2:0] {
    StPwrup, StAutoinit, StIdle, StDecode, StIssue, StWait, StComplete, StHoldoff
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      cmd_q;
  logic            prio_cal_q;   // 1: cal wins a tie
  logic            owner_cal_q;
  logic            owned_q;      // 0 while serving the automatic init

  logic grant_cal;
  logic dec_issue;
  logic dec_err;
  logic cmpl_err;

  always_comb begin
    grant_cal = cal_req && (!host_req || prio_cal_q);
    dec_issue = 1'b0;
    dec_err   = 1'b0;
    unique case (cmd_q)
      CmdInit:   dec_issue = 1'b1;
      CmdDesEn:  if (!adc_ready) dec_err = 1'b1; else dec_issue = !des_active;
      CmdDesDis: if (!adc_ready) dec_err = 1'b1; else dec_issue = des_active;
      default:   dec_err = 1'b1;
    endcase
    // A WAIT completion is an error only when no done arrived in time.
    cmpl_err = !adc_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StPwrup;
      cnt_q           <= '0;
      cmd_q           <= 2'b00;
      prio_cal_q      <= 1'b0;
      owner_cal_q     <= 1'b0;
      owned_q         <= 1'b0;
      host_ack        <= 1'b0;
      host_err        <= 1'b0;
      cal_ack         <= 1'b0;
      cal_err         <= 1'b0;
      adc_init        <= 1'b0;
      adc_des_enable  <= 1'b0;
      adc_des_disable <= 1'b0;
      busy            <= 1'b1;
      adc_ready       <= 1'b0;
      des_active      <= 1'b0;
      timeout_flag    <= 1'b0;
    end else begin
      host_ack        <= 1'b0;
      host_err        <= 1'b0;
      cal_ack         <= 1'b0;
      cal_err         <= 1'b0;
      adc_init        <= 1'b0;
      adc_des_enable  <= 1'b0;
      adc_des_disable <= 1'b0;
      if (clr_timeout) timeout_flag <= 1'b0;

      unique case (state_q)
        StPwrup: begin
          if (cnt_q == PwrupLast) begin
            state_q  <= StAutoinit;
            cnt_q    <= '0;
            cmd_q    <= CmdInit;
            owned_q  <= 1'b0;
            adc_init <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StAutoinit: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StIdle: begin
          if (host_req || cal_req) begin
            state_q     <= StDecode;
            busy        <= 1'b1;
            owned_q     <= 1'b1;
            owner_cal_q <= grant_cal;
            prio_cal_q  <= !grant_cal;
            cmd_q       <= grant_cal ? cal_cmd : host_cmd;
          end
        end
        StDecode: begin
          if (dec_issue) begin
            state_q         <= StIssue;
            adc_init        <= (cmd_q == CmdInit);
            adc_des_enable  <= (cmd_q == CmdDesEn);
            adc_des_disable <= (cmd_q == CmdDesDis);
          end else begin
            state_q  <= StComplete;
            host_ack <= !owner_cal_q;
            host_err <= !owner_cal_q && dec_err;
            cal_ack  <= owner_cal_q;
            cal_err  <= owner_cal_q && dec_err;
          end
        end
        StIssue: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          if (adc_done || cnt_q == TimeoutLast) begin
            state_q  <= StComplete;
            host_ack <= owned_q && !owner_cal_q;
            host_err <= owned_q && !owner_cal_q && cmpl_err;
            cal_ack  <= owned_q && owner_cal_q;
            cal_err  <= owned_q && owner_cal_q && cmpl_err;
            if (!adc_done) begin
              // Overrides a coincident clr_timeout.
              timeout_flag <= 1'b1;
              adc_ready    <= 1'b0;
            end else begin
              unique case (cmd_q)
                CmdInit: begin
                  adc_ready  <= 1'b1;
                  des_active <= 1'b0;
                end
                CmdDesEn:  des_active <= 1'b1;
                CmdDesDis: des_active <= 1'b0;
                default:   ;
              endcase
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StComplete: begin
          cnt_q <= '0;
          if (GAP_CYCLES == 0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            state_q <= StHoldoff;
          end
        end
        StHoldoff: begin
          if (cnt_q == GapLast) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StPwrup;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_cmd_scheduler.sv
// Randomized self-checking bench for adc_cmd_scheduler; expected cycles come from the
// transaction timing rules and a status model held in plain variables.
module tb_adc_cmd_scheduler;

  localparam int PWRUP   = 20;
  localparam int TIMEOUT = 40;
  localparam int GAP     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_req = 1'b0, cal_req = 1'b0;
  logic [1:0] host_cmd = 2'b00, cal_cmd = 2'b00;
  logic       host_ack, host_err, cal_ack, cal_err;
  logic       adc_init, adc_des_enable, adc_des_disable;
  logic       adc_done = 1'b0, clr_timeout = 1'b0;
  logic       busy, adc_ready, des_active, timeout_flag;

  int errors = 0;
  int checks = 0;

  // Reference status model
  bit m_ready, m_des, m_tflag, m_prio_cal;

  adc_cmd_scheduler #(
    .PWRUP_CYCLES  (PWRUP),
    .TIMEOUT_CYCLES(TIMEOUT),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host_req       (host_req),
    .host_cmd       (host_cmd),
    .host_ack       (host_ack),
    .host_err       (host_err),
    .cal_req        (cal_req),
    .cal_cmd        (cal_cmd),
    .cal_ack        (cal_ack),
    .cal_err        (cal_err),
    .adc_init       (adc_init),
    .adc_des_enable (adc_des_enable),
    .adc_des_disable(adc_des_disable),
    .adc_done       (adc_done),
    .clr_timeout    (clr_timeout),
    .busy           (busy),
    .adc_ready      (adc_ready),
    .des_active     (des_active),
    .timeout_flag   (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0 issue, 1 skip, 2 reject
  function automatic int decide(input logic [1:0] cmd);
    if (cmd == 2'b00) return 2;
    if (cmd == 2'b01) return 0;
    if (!m_ready) return 2;
    if (cmd == 2'b10) return m_des ? 1 : 0;
    return m_des ? 0 : 1;
  endfunction

  function automatic logic [2:0] pulse_of(input logic [1:0] cmd);
    if (cmd == 2'b01) return 3'b100;
    if (cmd == 2'b10) return 3'b010;
    return 3'b001;
  endfunction

  // Reset, then power-up; lat < 0 means the auto-init never gets adc_done.
  task automatic powerup(input int lat);
    int cmpl, endc;
    logic [10:0] all;
    rst = 1'b1; host_req = 1'b0; cal_req = 1'b0; adc_done = 1'b0; clr_timeout = 1'b0;
    step(); step();
    all = {host_ack, host_err, cal_ack, cal_err, adc_init, adc_des_enable, adc_des_disable,
           adc_ready, des_active, timeout_flag, busy};
    checks++;
    if (all !== 11'b00000000001) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000001", all);
    end
    rst = 1'b0;
    m_ready = 0; m_des = 0; m_tflag = 0; m_prio_cal = 0;
    cmpl = (lat < 0) ? PWRUP + TIMEOUT + 1 : PWRUP + lat + 1;
    endc = cmpl + GAP + 1;
    for (int c = 0; c <= endc; c++) begin
      if (c > 0) step();
      adc_done = (lat > 0 && c == PWRUP + lat);
      checks++;
      if ({adc_init, adc_des_enable, adc_des_disable} !== ((c == PWRUP) ? 3'b100 : 3'b000)) begin
        errors++;
        $display("FAIL pwrup_pulse c=%0d: got %b", c, {adc_init, adc_des_enable, adc_des_disable});
      end
      checks++;
      if ({host_ack, cal_ack, host_err, cal_err} !== 4'b0000) begin
        errors++;
        $display("FAIL pwrup_ack c=%0d: got %b want 0000", c, {host_ack, cal_ack, host_err, cal_err});
      end
      if (c == cmpl) begin
        if (lat < 0) begin m_tflag = 1; m_ready = 0; end
        else begin m_ready = 1; m_des = 0; end
        checks++;
        if ({adc_ready, des_active, timeout_flag} !== {m_ready, m_des, m_tflag}) begin
          errors++;
          $display("FAIL pwrup_status: got %b want %b", {adc_ready, des_active, timeout_flag},
                   {m_ready, m_des, m_tflag});
        end
      end
      checks++;
      if (busy !== (c < endc)) begin
        errors++;
        $display("FAIL pwrup_busy c=%0d: got %b want %b", c, busy, (c < endc));
      end
    end
  endtask

  // One arbitration round starting in an IDLE cycle. lat < 0: no done (timeout, with
  // clr_timeout raised in the last wait cycle). stray: adc_done pulsed during DECODE.
  task automatic run_one(input bit rh, input bit rc, input logic [1:0] ch, input logic [1:0] cc,
                         input int lat, input bit stray, output bit got_cal);
    bit win_cal, err_exp;
    logic [1:0] cmd;
    logic [2:0] pexp;
    logic [3:0] aexp;
    int kind, p, ack_cyc, endc;
    win_cal = rc && (!rh || m_prio_cal);
    cmd = win_cal ? cc : ch;
    kind = decide(cmd);
    if (kind == 0) begin
      p = 2;
      ack_cyc = (lat < 0) ? p + TIMEOUT + 1 : p + lat + 1;
      err_exp = (lat < 0);
    end else begin
      p = -1;
      ack_cyc = 2;
      err_exp = (kind == 2);
    end
    endc = ack_cyc + GAP + 1;
    m_prio_cal = !win_cal;
    got_cal = 1'b0;
    host_req = rh; cal_req = rc; host_cmd = ch; cal_cmd = cc;
    for (int c = 0; c <= endc; c++) begin
      if (c > 0) step();
      adc_done = (kind == 0 && lat > 0 && c == p + lat) || (stray && c == 1);
      clr_timeout = (kind == 0 && lat < 0 && c == p + TIMEOUT);
      if (c == ack_cyc + 1) begin
        if (win_cal) cal_req = 1'b0; else host_req = 1'b0;
      end
      if (cal_ack) got_cal = 1'b1;
      pexp = (c == p) ? pulse_of(cmd) : 3'b000;
      checks++;
      if ({adc_init, adc_des_enable, adc_des_disable} !== pexp) begin
        errors++;
        $display("FAIL pulse c=%0d cmd=%b: got %b want %b", c, cmd,
                 {adc_init, adc_des_enable, adc_des_disable}, pexp);
      end
      aexp = (c != ack_cyc) ? 4'b0000 : (win_cal ? {2'b00, 1'b1, err_exp}
                                                 : {1'b1, err_exp, 2'b00});
      checks++;
      if ({host_ack, host_err, cal_ack, cal_err} !== aexp) begin
        errors++;
        $display("FAIL ack c=%0d cmd=%b: got %b want %b", c, cmd,
                 {host_ack, host_err, cal_ack, cal_err}, aexp);
      end
      checks++;
      if (busy !== (c > 0 && c < endc)) begin
        errors++;
        $display("FAIL busy c=%0d: got %b want %b", c, busy, (c > 0 && c < endc));
      end
      if (c == ack_cyc && kind == 0) begin
        if (lat < 0) begin m_tflag = 1; m_ready = 0; end
        else if (cmd == 2'b01) begin m_ready = 1; m_des = 0; end
        else m_des = (cmd == 2'b10);
      end
      if (c == ack_cyc || c == endc) begin
        checks++;
        if ({adc_ready, des_active, timeout_flag} !== {m_ready, m_des, m_tflag}) begin
          errors++;
          $display("FAIL status c=%0d: got %b want %b", c, {adc_ready, des_active, timeout_flag},
                   {m_ready, m_des, m_tflag});
        end
      end
    end
    adc_done = 1'b0;
    clr_timeout = 1'b0;
  endtask

  task automatic test_reset_powerup();
    powerup(3);
  endtask

  task automatic test_arbitration();
    bit g;
    run_one(1, 1, 2'b10, 2'b10, 4, 0, g);
    checks++;
    if (g !== 1'b0) begin errors++; $display("FAIL arb_first: got cal=%b want 0", g); end
    run_one(0, 1, 2'b10, 2'b10, 4, 0, g);
    checks++;
    if (g !== 1'b1) begin errors++; $display("FAIL arb_second: got cal=%b want 1", g); end
  endtask

  task automatic test_pre_ready_reject();
    bit g;
    powerup(-1);
    run_one(0, 1, 2'b00, 2'b10, 3, 0, g);
  endtask

  task automatic test_illegal_recovery();
    bit g;
    run_one(1, 0, 2'b00, 2'b00, 3, 0, g);
    run_one(1, 0, 2'b01, 2'b00, 5, 0, g);
    checks++;
    if (timeout_flag !== 1'b1) begin
      errors++; $display("FAIL tflag_sticky: got %b want 1", timeout_flag);
    end
    clr_timeout = 1'b1;
    step();
    clr_timeout = 1'b0;
    m_tflag = 0;
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++; $display("FAIL tflag_clear: got %b want 0", timeout_flag);
    end
  endtask

  task automatic test_fairness();
    bit g, first, exp_first;
    run_one(1, 0, 2'b10, 2'b00, 2, 0, g);
    exp_first = m_prio_cal;
    for (int i = 0; i < 6; i++) begin
      run_one(1, 1, 2'b11, 2'b11, 2, 0, g);
      if (i == 0) first = g;
      checks++;
      if (g !== (exp_first ^ i[0])) begin
        errors++;
        $display("FAIL rr_grant %0d: got cal=%b want %b (first=%b)", i, g, exp_first ^ i[0], first);
      end
    end
  endtask

  task automatic test_random();
    bit g, rh, rc, st;
    int r, lat;
    for (int i = 0; i < 24; i++) begin
      rh = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (!rh && !rc) rc = 1'b1;
      r = $urandom_range(0, 9);
      lat = (r == 0) ? -1 : (r == 1) ? TIMEOUT : r - 1;
      st = 1'($urandom_range(0, 1));
      run_one(rh, rc, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), lat, st, g);
    end
    host_req = 1'b0; cal_req = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit g;
    logic [10:0] all;
    run_one(1, 0, 2'b01, 2'b00, 2, 0, g);
    run_one(1, 0, 2'b10, 2'b00, 2, 0, g);
    host_req = 1'b1; host_cmd = 2'b11;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 2) begin
        checks++;
        if (adc_des_disable !== 1'b1) begin
          errors++; $display("FAIL midwait_pulse: got %b want 1", adc_des_disable);
        end
      end
    end
    host_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    all = {host_ack, host_err, cal_ack, cal_err, adc_init, adc_des_enable, adc_des_disable,
           adc_ready, des_active, timeout_flag, busy};
    checks++;
    if (all !== 11'b00000000001) begin
      errors++; $display("FAIL async_reset: got %b want 00000000001", all);
    end
    powerup(3);
  endtask

  initial begin
    test_reset_powerup();
    test_arbitration();
    test_pre_ready_reject();
    test_illegal_recovery();
    test_fairness();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
